// File: rtl/apb_master_if_pkg.sv
// apb_master_if_pkg: APB state encoding shared with the slave, default widths and counter sizing
package apb_master_if_pkg;
  typedef enum logic [1:0] {
    APB_IDLE   = 2'b00,
    APB_SETUP  = 2'b01,
    APB_ACCESS = 2'b10
  } apb_state_e;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 32;
  function automatic int cnt_w(input int t);
    return (t > 0) ? $clog2(t + 1) : 1;
  endfunction
endpackage

// File: rtl/apb_master_if_if.sv
// apb_master_if_if: command/response port plus APB bus seen by the requester (master) and its peers (slave)
interface apb_master_if_if import apb_master_if_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              busy;
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic              PREADY;
  logic [DATA_W-1:0] PRDATA;
  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, PREADY, PRDATA,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy,
           PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );
  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, PREADY, PRDATA,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy,
           PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );
endinterface

// File: rtl/apb_master_if_wait_timer.sv
// apb_wait_timer: counts ACCESS wait cycles and flags the cycle on which the transfer must abort
module apb_wait_timer import apb_master_if_pkg::*; #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic inc,
  output logic expire
);
  localparam int W = cnt_w(TIMEOUT);
  localparam logic [W-1:0] LIM = W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  logic [W-1:0] count;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else if (clear) count <= '0;
    else if (inc) count <= count + 1'b1;
  // TIMEOUT of zero disables the abort entirely; the counter then just wraps
  assign expire = (TIMEOUT > 0) && inc && (count == LIM);
endmodule

// File: rtl/apb_master_if.sv
// apb_master_if: single-outstanding APB requester; IDLE->SETUP->ACCESS with wait states and timeout abort
module apb_master_if import apb_master_if_pkg::*; #(
  parameter int TIMEOUT = 16
) (
  input logic              PCLK,
  input logic              PRESETn,
  apb_master_if_if.master  bus
);
  apb_state_e state, nxt;
  logic acc, waiting, done, expire;
  assign acc     = bus.cmd_valid & bus.cmd_ready;
  assign waiting = (state == APB_ACCESS) & ~bus.PREADY;
  assign done    = (state == APB_ACCESS) & (bus.PREADY | expire);
  apb_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk    (PCLK),
    .rst_n  (PRESETn),
    .clear  (acc),
    .inc    (waiting),
    .expire (expire)
  );
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) state <= APB_IDLE;
    else state <= nxt;
  // cmd_ready is gated by reset so every output reads 0 while PRESETn is low
  always_comb begin
    nxt           = APB_IDLE;
    bus.PSEL      = 1'b0;
    bus.PENABLE   = 1'b0;
    bus.busy      = 1'b0;
    bus.cmd_ready = 1'b0;
    case (state)
      APB_IDLE: begin
        bus.cmd_ready = PRESETn;
        nxt           = bus.cmd_valid ? APB_SETUP : APB_IDLE;
      end
      APB_SETUP: begin
        bus.PSEL = 1'b1;
        bus.busy = 1'b1;
        nxt      = APB_ACCESS;
      end
      APB_ACCESS: begin
        bus.PSEL      = 1'b1;
        bus.PENABLE   = 1'b1;
        bus.busy      = 1'b1;
        bus.cmd_ready = bus.PREADY;
        nxt           = bus.PREADY ? (bus.cmd_valid ? APB_SETUP : APB_IDLE)
                                   : (expire ? APB_IDLE : APB_ACCESS);
      end
      default: nxt = APB_IDLE;
    endcase
  end
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) begin
      bus.PWRITE <= 1'b0;
      bus.PADDR  <= '0;
      bus.PWDATA <= '0;
    end else if (acc) begin
      bus.PWRITE <= bus.cmd_write;
      bus.PADDR  <= bus.cmd_addr;
      bus.PWDATA <= bus.cmd_wdata;
    end
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      bus.rsp_valid <= done;
      if (done) begin
        bus.rsp_err   <= ~bus.PREADY;
        bus.rsp_rdata <= (bus.PREADY & ~bus.PWRITE) ? bus.PRDATA : '0;
      end
    end
endmodule

// File: tb/tb_apb_master_if.sv
// tb_apb_master_if: randomized transfers against a transaction-level model of latency, response and stability
module tb_apb_master_if;
  localparam int TO = 8;
  logic PCLK = 1'b0;
  logic PRESETn = 1'b0;
  apb_master_if_if #(.ADDR_W(4), .DATA_W(32)) bus ();
  apb_master_if #(.TIMEOUT(TO)) dut (.PCLK(PCLK), .PRESETn(PRESETn), .bus(bus));
  always #5 PCLK = ~PCLK;
  int cmp = 0;
  int bad = 0;
  int wait_cfg = 0;
  int acnt = 0;
  bit tie = 1'b0;
  logic [31:0] rd_data = '0;
  // Slave: PREADY rises on the (wait_cfg+1)-th ACCESS cycle, or always when tied
  always @(negedge PCLK) begin
    if (bus.PSEL && bus.PENABLE) begin
      bus.PREADY = tie || (acnt == wait_cfg);
      acnt++;
    end else begin
      bus.PREADY = tie;
      acnt = 0;
    end
    bus.PRDATA = rd_data;
  end
  function automatic int exp_psel(input int waits);
    return (waits >= TO) ? TO + 1 : waits + 2;
  endfunction
  task automatic xfer(input logic w, input logic [3:0] a, input logic [31:0] d, input int waits,
                      input logic [31:0] rd, output int ps, output int pe, output int nr, output int rdy,
                      output logic [31:0] rdata, output logic err, output bit st, output bit hd);
    @(negedge PCLK); #1;
    wait_cfg = waits; rd_data = rd;
    bus.cmd_valid = 1'b1; bus.cmd_write = w; bus.cmd_addr = a; bus.cmd_wdata = d;
    @(negedge PCLK); #1;
    bus.cmd_valid = 1'b0;
    ps = 0; pe = 0; nr = 0; rdy = 0; rdata = '0; err = 1'b0; st = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (bus.PSEL) begin
        ps++;
        if (bus.cmd_ready) rdy++;
        if (bus.PADDR !== a || bus.PWDATA !== d || bus.PWRITE !== w) st = 1'b0;
      end
      if (bus.PENABLE) pe++;
      if (bus.rsp_valid) begin nr++; rdata = bus.rsp_rdata; err = bus.rsp_err; end
      bus.cmd_addr = 4'($urandom); bus.cmd_wdata = $urandom; bus.cmd_write = 1'($urandom);
      @(negedge PCLK); #1;
    end
    hd = (bus.rsp_rdata === rdata) && (bus.rsp_err === err);
  endtask
  task automatic test_reset();
    #2;
    cmp++;
    if ({bus.PSEL, bus.PENABLE, bus.busy, bus.cmd_ready, bus.rsp_valid, bus.rsp_err, bus.PWRITE,
         bus.PADDR, bus.PWDATA, bus.rsp_rdata} !== '0) begin
      bad++; $display("FAIL reset_outputs psel=%b pen=%b busy=%b rdy=%b rv=%b", bus.PSEL, bus.PENABLE,
                      bus.busy, bus.cmd_ready, bus.rsp_valid);
    end
    @(negedge PCLK); PRESETn = 1'b1; #1;
    cmp++;
    if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL idle_ready got=%b exp=1", bus.cmd_ready); end
  endtask
  task automatic test_write();
    int ps, pe, nr, rdy; logic [31:0] rd; logic er; bit st, hd;
    tie = 1'b0;
    xfer(1'b1, 4'h4, 32'hDEADBEEF, 1, 32'h12345678, ps, pe, nr, rdy, rd, er, st, hd);
    cmp++; if (ps !== 3) begin bad++; $display("FAIL write_psel got=%0d exp=3", ps); end
    cmp++; if (pe !== 2) begin bad++; $display("FAIL write_penable got=%0d exp=2", pe); end
    cmp++; if (nr !== 1) begin bad++; $display("FAIL write_rsp_count got=%0d exp=1", nr); end
    cmp++; if (er !== 1'b0 || rd !== 32'h0) begin bad++; $display("FAIL write_rsp got err=%b rdata=%h exp err=0 rdata=0", er, rd); end
    cmp++; if (!st) begin bad++; $display("FAIL write_stable got=0 exp=1"); end
  endtask
  task automatic test_read();
    int ps, pe, nr, rdy; logic [31:0] rd; logic er; bit st, hd;
    tie = 1'b1;
    xfer(1'b0, 4'h8, 32'h0, 0, 32'hA5A55A5A, ps, pe, nr, rdy, rd, er, st, hd);
    tie = 1'b0;
    cmp++; if (ps !== 2) begin bad++; $display("FAIL read_psel got=%0d exp=2", ps); end
    cmp++; if (rd !== 32'hA5A55A5A || er !== 1'b0) begin bad++; $display("FAIL read_rdata got=%h err=%b exp=a5a55a5a err=0", rd, er); end
    cmp++; if (nr !== 1) begin bad++; $display("FAIL read_rsp_count got=%0d exp=1", nr); end
  endtask
  task automatic test_back_to_back();
    logic [3:0] a1, a2; logic [31:0] d1, r2; logic [7:0] psv, pev; logic [31:0] rq[$];
    a1 = 4'($urandom); a2 = ~a1; d1 = $urandom; r2 = $urandom;
    tie = 1'b0; wait_cfg = 0; rd_data = r2; psv = '0; pev = '0;
    @(negedge PCLK); #1;
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = a1; bus.cmd_wdata = d1;
    @(negedge PCLK); #1;
    bus.cmd_write = 1'b0; bus.cmd_addr = a2; bus.cmd_wdata = $urandom;
    for (int i = 0; i < 8; i++) begin
      psv[i] = bus.PSEL; pev[i] = bus.PENABLE;
      if (bus.rsp_valid) rq.push_back(bus.rsp_rdata);
      if (i == 0) begin cmp++; if (bus.cmd_ready !== 1'b0) begin bad++; $display("FAIL b2b_setup_ready got=%b exp=0", bus.cmd_ready); end end
      if (i == 1) begin cmp++; if (bus.cmd_ready !== 1'b1 || bus.PADDR !== a1) begin bad++; $display("FAIL b2b_first_access ready=%b paddr=%h exp ready=1 paddr=%h", bus.cmd_ready, bus.PADDR, a1); end end
      if (i == 2) begin
        bus.cmd_valid = 1'b0;
        cmp++; if (bus.PADDR !== a2 || bus.PWRITE !== 1'b0) begin bad++; $display("FAIL b2b_second_latch paddr=%h pwrite=%b exp paddr=%h pwrite=0", bus.PADDR, bus.PWRITE, a2); end
      end
      @(negedge PCLK); #1;
    end
    cmp++; if (psv !== 8'b0000_1111) begin bad++; $display("FAIL b2b_psel got=%b exp=00001111", psv); end
    cmp++; if (pev !== 8'b0000_1010) begin bad++; $display("FAIL b2b_penable got=%b exp=00001010", pev); end
    cmp++;
    if (rq.size() != 2 || rq[0] !== 32'h0 || rq[1] !== r2) begin
      bad++; $display("FAIL b2b_rsp got count=%0d exp count=2 last=%h", rq.size(), r2);
    end
  endtask
  task automatic test_timeout();
    int ps, pe, nr, rdy; logic [31:0] rd, r; logic er; bit st, hd;
    tie = 1'b0; r = $urandom;
    xfer(1'b0, 4'($urandom), $urandom, 20, r, ps, pe, nr, rdy, rd, er, st, hd);
    cmp++; if (ps !== TO + 1 || pe !== TO) begin bad++; $display("FAIL timeout_len got psel=%0d pen=%0d exp psel=%0d pen=%0d", ps, pe, TO + 1, TO); end
    cmp++; if (er !== 1'b1 || rd !== 32'h0 || nr !== 1) begin bad++; $display("FAIL timeout_rsp got err=%b rdata=%h n=%0d exp err=1 rdata=0 n=1", er, rd, nr); end
    xfer(1'b0, 4'($urandom), $urandom, TO - 1, r, ps, pe, nr, rdy, rd, er, st, hd);
    cmp++; if (ps !== TO + 1 || er !== 1'b0 || rd !== r) begin bad++; $display("FAIL timeout_edge got psel=%0d err=%b rdata=%h exp psel=%0d err=0 rdata=%h", ps, er, rd, TO + 1, r); end
  endtask
  task automatic test_stable();
    int ps, pe, nr, rdy; logic [31:0] rd; logic er; bit st, hd;
    xfer(1'b1, 4'($urandom), $urandom, 5, $urandom, ps, pe, nr, rdy, rd, er, st, hd);
    cmp++; if (!st) begin bad++; $display("FAIL stable_bus got=0 exp=1"); end
    cmp++; if (rdy !== 1 || ps !== 7) begin bad++; $display("FAIL stable_ready got ready_cycles=%0d psel=%0d exp 1 and 7", rdy, ps); end
  endtask
  task automatic test_reset_mid();
    int ps, pe, nr, rdy, n; logic [31:0] rd, r; logic er; bit st, hd;
    tie = 1'b0; wait_cfg = 20;
    @(negedge PCLK); #1;
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 4'hF; bus.cmd_wdata = 32'hFFFF_FFFF;
    @(negedge PCLK); #1;
    bus.cmd_valid = 1'b0;
    repeat (3) @(negedge PCLK);
    #1;
    cmp++; if (bus.PENABLE !== 1'b1) begin bad++; $display("FAIL rst_mid_inflight got penable=%b exp=1", bus.PENABLE); end
    #1; PRESETn = 1'b0; #1;
    cmp++;
    if ({bus.PSEL, bus.PENABLE, bus.busy, bus.cmd_ready, bus.rsp_valid, bus.PWRITE, bus.PADDR, bus.PWDATA} !== '0) begin
      bad++; $display("FAIL rst_mid_outputs psel=%b pen=%b busy=%b paddr=%h exp all 0", bus.PSEL, bus.PENABLE, bus.busy, bus.PADDR);
    end
    @(negedge PCLK); #1; PRESETn = 1'b1;
    n = 0;
    repeat (6) begin @(negedge PCLK); #1; if (bus.rsp_valid) n++; end
    cmp++; if (n !== 0) begin bad++; $display("FAIL rst_mid_no_rsp got=%0d exp=0", n); end
    r = $urandom;
    xfer(1'b0, 4'h3, $urandom, 2, r, ps, pe, nr, rdy, rd, er, st, hd);
    cmp++; if (ps !== 4 || rd !== r || er !== 1'b0 || nr !== 1) begin bad++; $display("FAIL rst_mid_recover got psel=%0d rdata=%h err=%b n=%0d exp 4 %h 0 1", ps, rd, er, nr, r); end
  endtask
  task automatic test_random();
    int ps, pe, nr, rdy, wt; logic [31:0] rd, r, d; logic [3:0] a; logic er, w, e_err; bit st, hd;
    tie = 1'b0;
    for (int k = 0; k < 16; k++) begin
      w = 1'($urandom); a = 4'($urandom); d = $urandom; r = $urandom; wt = $urandom_range(0, 10);
      e_err = (wt >= TO);
      xfer(w, a, d, wt, r, ps, pe, nr, rdy, rd, er, st, hd);
      cmp++; if (ps !== exp_psel(wt) || pe !== exp_psel(wt) - 1) begin bad++; $display("FAIL rand%0d_len got psel=%0d pen=%0d exp psel=%0d", k, ps, pe, exp_psel(wt)); end
      cmp++; if (nr !== 1 || er !== e_err) begin bad++; $display("FAIL rand%0d_rsp got n=%0d err=%b exp n=1 err=%b", k, nr, er, e_err); end
      cmp++; if (rd !== ((!w && !e_err) ? r : 32'h0)) begin bad++; $display("FAIL rand%0d_rdata got=%h exp=%h", k, rd, (!w && !e_err) ? r : 32'h0); end
      cmp++; if (!st || !hd) begin bad++; $display("FAIL rand%0d_hold got stable=%b held=%b exp 1 1", k, st, hd); end
      cmp++; if (rdy !== (e_err ? 0 : 1)) begin bad++; $display("FAIL rand%0d_ready got=%0d exp=%0d", k, rdy, e_err ? 0 : 1); end
    end
  endtask
  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
    bus.PREADY = 1'b0; bus.PRDATA = '0;
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_timeout();
    test_stable();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
